text_buffer: RTL and testbench
==============================

Name: text_buffer

Overview:
- Parametrised character-cell text buffer for the VGA text path.
- Accepts ASCII characters from the keyboard/lookup chain over a valid/ready handshake and stores them at a hardware cursor.
- Handles newline, backspace, form-feed clear and automatic scroll-up when text passes the last row.
- Gives the font renderer a registered random-access read port addressed by (row, col).

Parameters:
- COLS, 70, characters per row (>=2).
- ROWS, 30, rows on screen (>=2).
- CHAR_W, 8, character code width.
- CW (derived), $clog2(COLS), column index width.
- RW (derived), $clog2(ROWS), row index width.

Ports:
- clk  in  1  system clock; everything updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_char is valid.
- in_char  in  CHAR_W  character code.
- in_ready  out  1  block can accept a character this cycle.
- rd_row  in  RW  display read row.
- rd_col  in  CW  display read column.
- rd_char  out  CHAR_W  registered cell contents.
- cursor_row  out  RW  current cursor row.
- cursor_col  out  CW  current cursor column.
- busy  out  1  scroll or clear in progress (equal to ~in_ready).

Behaviour:
- Storage: COLS*ROWS cells, linear address = row*COLS + col.
- Internal write path: one write per cycle, with a combinational internal read for copying.
- Handshake: a character is accepted on an edge where in_valid & in_ready. in_char is not sampled otherwise.
- Reset (resetn=0):
  - cursor goes to (0,0); rd_char=0; in_ready=0; busy=1.
  - FSM goes to CLR_ALL.
  - Reset is legal mid-scroll: the operation is abandoned and CLR_ALL restarts.
- FSM states: IDLE, SCROLL, CLR_LINE, CLR_ALL.
  - CLR_ALL: writes 0x20 to addresses 0..COLS*ROWS-1, one per cycle (COLS*ROWS cycles), then goes to IDLE.
  - IDLE: in_ready=1. An accepted code is decoded as follows.
    - 0x20..0x7E: written at the cursor on the accept edge. The cursor then advances col+1. At col=COLS-1 it wraps to col 0, row+1. At row=ROWS-1 with col=COLS-1 the cursor goes to (ROWS-1,0) and the FSM goes to SCROLL.
    - 0x0A (newline): col=0. If row<ROWS-1 then row+1; otherwise the cursor goes to (ROWS-1,0) and the FSM goes to SCROLL.
    - 0x08 (backspace):
      - If col>0: col-1 and write 0x20 at the new position.
      - If col=0 and row>0: cursor to (row-1, COLS-1) and write 0x20 there.
      - At (0,0): no operation.
    - 0x0C (form feed): cursor to (0,0), FSM to CLR_ALL.
    - All other codes are consumed with no effect.
  - SCROLL: for i = 0..COLS*(ROWS-1)-1, one per cycle: mem[i] <= mem[i+COLS]. Then goes to CLR_LINE.
  - CLR_LINE: writes 0x20 to the last row, COLS cycles, then goes to IDLE.
  - Total scroll occupancy is exactly COLS*ROWS cycles. in_ready is low from the edge after the triggering accept until the FSM returns to IDLE.
- Read port:
  - rd_char <= mem[addr(rd_row, rd_col)] every edge: 1-cycle latency, read-before-write for a same-edge write.
  - Out-of-range row or column returns 0x00.
  - During SCROLL or CLR the read returns the current partial contents; no stall.
- Cursor outputs are registered, update on the accept edge, and are never out of range.

Test Plan:
- Reset with COLS=4, ROWS=3 -> in_ready=0 for 12 cycles then 1. Every cell reads 0x20; cursor=(0,0).
- Send 'A','B','C','D','E' back-to-back -> cells (0,0..3)=41..44 and (1,0)=45; cursor=(1,1). rd_char for (0,2) equals 0x43 one cycle after the address is applied.
- Send 0x0A twice from (1,1), then fill row 2 -> scroll triggers: busy high for exactly 12 cycles. Afterwards row 0 = old row 1, row 1 = old row 2, row 2 = all 0x20; cursor=(2,0).
- Backspace at (1,0) -> cursor (0,3), cell (0,3)=0x20. Backspace at (0,0) -> no change, in_ready stays 1.
- Send 0x0C mid-text -> 12-cycle clear, all cells 0x20, cursor (0,0). Hold in_valid with 'Z' during the clear -> 'Z' is accepted only on the first cycle in_ready=1.
- Assert resetn=0 for one cycle during SCROLL -> cursor (0,0), CLR_ALL restarts, screen blank after 12 cycles. Code 0x07 in IDLE -> accepted, no cell or cursor change.

Source files
------------

// File: rtl/text_buffer.sv
// Character-cell text buffer: stores keyboard characters at a hardware cursor,
// handles newline/backspace/form-feed/scroll and serves a registered (row,col) read port.
module text_buffer #(
  parameter int COLS   = 70,
  parameter int ROWS   = 30,
  parameter int CHAR_W = 8,
  parameter int CW     = $clog2(COLS),
  parameter int RW     = $clog2(ROWS)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  input  logic [CHAR_W-1:0] in_char,
  output logic              in_ready,
  input  logic [RW-1:0]     rd_row,
  input  logic [CW-1:0]     rd_col,
  output logic [CHAR_W-1:0] rd_char,
  output logic [RW-1:0]     cursor_row,
  output logic [CW-1:0]     cursor_col,
  output logic              busy
);

  localparam int CELLS = COLS * ROWS;
  localparam int AW    = $clog2(CELLS);

  localparam logic [AW-1:0]     LAST_CELL = AW'(CELLS - 1);
  localparam logic [AW-1:0]     LAST_COPY = AW'(CELLS - COLS - 1);
  localparam logic [AW-1:0]     COLS_A    = AW'(COLS);
  localparam logic [CW-1:0]     LAST_COL  = CW'(COLS - 1);
  localparam logic [RW-1:0]     LAST_ROW  = RW'(ROWS - 1);
  localparam logic [CHAR_W-1:0] SPACE     = CHAR_W'(8'h20);
  localparam logic [CHAR_W-1:0] TILDE     = CHAR_W'(8'h7E);
  localparam logic [CHAR_W-1:0] LF        = CHAR_W'(8'h0A);
  localparam logic [CHAR_W-1:0] BS        = CHAR_W'(8'h08);
  localparam logic [CHAR_W-1:0] FF        = CHAR_W'(8'h0C);

  typedef enum logic [1:0] {IDLE, SCROLL, CLR_LINE, CLR_ALL} state_t;

  state_t            state_reg, state_next;
  logic [AW-1:0]     cnt_reg, cnt_next;
  logic [RW-1:0]     cursor_row_reg, row_next;
  logic [CW-1:0]     cursor_col_reg, col_next;
  logic [CHAR_W-1:0] rd_char_reg;

  logic [CHAR_W-1:0] mem [CELLS];

  logic              we;
  logic [AW-1:0]     waddr;
  logic [CHAR_W-1:0] wdata;
  logic [AW-1:0]     cursor_addr;
  logic [AW-1:0]     raddr;
  logic              rd_in_range;
  logic [CHAR_W-1:0] copy_char;

  assign cursor_addr = AW'(cursor_row_reg) * COLS_A + AW'(cursor_col_reg);
  assign raddr       = AW'(rd_row) * COLS_A + AW'(rd_col);
  assign rd_in_range = (int'(rd_row) < ROWS) && (int'(rd_col) < COLS);
  // Only consumed in SCROLL, where cnt_reg + COLS always stays inside the array.
  assign copy_char   = mem[cnt_reg + COLS_A];

  assign in_ready   = (state_reg == IDLE);
  assign busy       = ~in_ready;
  assign rd_char    = rd_char_reg;
  assign cursor_row = cursor_row_reg;
  assign cursor_col = cursor_col_reg;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    row_next   = cursor_row_reg;
    col_next   = cursor_col_reg;
    we         = 1'b0;
    waddr      = cnt_reg;
    wdata      = SPACE;
    case (state_reg)
      CLR_ALL, CLR_LINE: begin
        we = 1'b1;
        if (cnt_reg == LAST_CELL) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + AW'(1);
        end
      end
      SCROLL: begin
        // The counter runs on into CLR_LINE so the last row is cleared without a reload.
        we       = 1'b1;
        wdata    = copy_char;
        cnt_next = cnt_reg + AW'(1);
        if (cnt_reg == LAST_COPY) state_next = CLR_LINE;
      end
      IDLE: begin
        if (in_valid) begin
          if (in_char >= SPACE && in_char <= TILDE) begin
            we    = 1'b1;
            waddr = cursor_addr;
            wdata = in_char;
            if (cursor_col_reg == LAST_COL) begin
              col_next = '0;
              if (cursor_row_reg == LAST_ROW) begin
                state_next = SCROLL;
                cnt_next   = '0;
              end else begin
                row_next = cursor_row_reg + RW'(1);
              end
            end else begin
              col_next = cursor_col_reg + CW'(1);
            end
          end else if (in_char == LF) begin
            col_next = '0;
            if (cursor_row_reg == LAST_ROW) begin
              state_next = SCROLL;
              cnt_next   = '0;
            end else begin
              row_next = cursor_row_reg + RW'(1);
            end
          end else if (in_char == BS) begin
            // Both the in-row and row-wrap cases land on linear address cursor-1.
            if (cursor_col_reg != '0) begin
              col_next = cursor_col_reg - CW'(1);
              we       = 1'b1;
              waddr    = cursor_addr - AW'(1);
            end else if (cursor_row_reg != '0) begin
              row_next = cursor_row_reg - RW'(1);
              col_next = LAST_COL;
              we       = 1'b1;
              waddr    = cursor_addr - AW'(1);
            end
          end else if (in_char == FF) begin
            row_next   = '0;
            col_next   = '0;
            state_next = CLR_ALL;
            cnt_next   = '0;
          end
        end
      end
      default: state_next = CLR_ALL;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= CLR_ALL;
      cnt_reg        <= '0;
      cursor_row_reg <= '0;
      cursor_col_reg <= '0;
      rd_char_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      cursor_row_reg <= row_next;
      cursor_col_reg <= col_next;
      rd_char_reg    <= rd_in_range ? mem[raddr] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

endmodule

// File: tb/tb_text_buffer.sv
// Directed bench for text_buffer with a 4x3 screen: reset clear, typing, scroll,
// backspace, form-feed with held input, ignored codes and reset during scroll.
module tb_text_buffer;

  localparam int COLS = 4;
  localparam int ROWS = 3;
  localparam int CW   = $clog2(COLS);
  localparam int RW   = $clog2(ROWS);

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_char = 8'h00;
  logic          in_ready;
  logic [RW-1:0] rd_row = '0;
  logic [CW-1:0] rd_col = '0;
  logic [7:0]    rd_char;
  logic [RW-1:0] cursor_row;
  logic [CW-1:0] cursor_col;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cycles;

  text_buffer #(.COLS(COLS), .ROWS(ROWS), .CHAR_W(8)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_char(in_char),
    .in_ready(in_ready), .rd_row(rd_row), .rd_col(rd_col), .rd_char(rd_char),
    .cursor_row(cursor_row), .cursor_col(cursor_col), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_cursor(input string tag, input int r, input int c);
    check({tag, "_row"}, 32'(cursor_row), r);
    check({tag, "_col"}, 32'(cursor_col), c);
  endtask

  task automatic read_cell(input int r, input int c, input logic [7:0] exp);
    rd_row = RW'(r);
    rd_col = CW'(c);
    tick();
    check($sformatf("cell(%0d,%0d)", r, c), 32'(rd_char), 32'(exp));
  endtask

  // Expected row contents packed with column 0 in the top byte.
  task automatic check_row(input int r, input logic [31:0] exp);
    for (int c = 0; c < COLS; c++) read_cell(r, c, exp[31 - 8*c -: 8]);
  endtask

  task automatic check_blank;
    for (int r = 0; r < ROWS; r++) check_row(r, 32'h20202020);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic send(input logic [7:0] ch);
    int n;
    wait_ready(n);
    check($sformatf("ready_for_%0h", ch), 32'(in_ready), 1);
    in_valid = 1'b1;
    in_char  = ch;
    tick();
    in_valid = 1'b0;
    in_char  = 8'h00;
  endtask

  initial begin
    // Reset state
    tick();
    check("rst_ready", 32'(in_ready), 0);
    check("rst_busy", 32'(busy), 1);
    check("rst_rd_char", 32'(rd_char), 0);
    check_cursor("rst_cursor", 0, 0);
    tick();
    resetn = 1'b1;
    wait_ready(cycles);
    check("rst_clear_cycles", cycles, 12);
    check_blank();
    read_cell(3, 0, 8'h00);
    check_cursor("post_rst_cursor", 0, 0);

    // Typing with wrap into row 1
    send("A"); send("B"); send("C"); send("D"); send("E");
    check_cursor("abcde_cursor", 1, 1);
    check_row(0, 32'h41424344);
    read_cell(1, 0, 8'h45);
    read_cell(0, 2, 8'h43);

    // Newline, then newline on the last row scrolls
    send(8'h0A);
    check_cursor("lf1_cursor", 2, 0);
    send(8'h0A);
    check("lf2_busy", 32'(busy), 1);
    check_cursor("lf2_cursor", 2, 0);
    wait_ready(cycles);
    check("lf2_scroll_cycles", cycles, 12);
    check_row(0, 32'h45202020);
    check_row(1, 32'h20202020);
    check_row(2, 32'h20202020);

    // Filling the last row scrolls on the final character
    send("1"); send("2"); send("3");
    check_cursor("fill3_cursor", 2, 3);
    send("4");
    check("fill_busy", 32'(busy), 1);
    check_cursor("fill_cursor", 2, 0);
    wait_ready(cycles);
    check("fill_scroll_cycles", cycles, 12);
    check_row(0, 32'h20202020);
    check_row(1, 32'h31323334);
    check_row(2, 32'h20202020);

    // Backspace across a row boundary
    send(8'h08);
    check_cursor("bs_wrap_cursor", 1, 3);
    check_row(1, 32'h31323320);

    // Form feed with 'Z' held valid throughout the clear
    send(8'h0C);
    check("ff_ready", 32'(in_ready), 0);
    check_cursor("ff_cursor", 0, 0);
    in_valid = 1'b1;
    in_char  = "Z";
    wait_ready(cycles);
    check("ff_clear_cycles", cycles, 12);
    check_cursor("ff_before_z", 0, 0);
    tick();
    in_valid = 1'b0;
    check_cursor("z_cursor", 0, 1);
    check_row(0, 32'h5A202020);
    check_row(1, 32'h20202020);
    check_row(2, 32'h20202020);

    // Backspace from (1,0), then back to the origin
    send("Q"); send("R"); send("S");
    check_cursor("qrs_cursor", 1, 0);
    send(8'h08);
    check_cursor("bs10_cursor", 0, 3);
    check_row(0, 32'h5A515220);
    send(8'h08); send(8'h08); send(8'h08);
    check_cursor("bs_home_cursor", 0, 0);
    check_row(0, 32'h20202020);
    send(8'h08);
    check_cursor("bs00_cursor", 0, 0);
    check("bs00_ready", 32'(in_ready), 1);

    // Unhandled control code is consumed without effect
    send("K");
    send(8'h07);
    check_cursor("bel_cursor", 0, 1);
    check("bel_ready", 32'(in_ready), 1);
    check_row(0, 32'h4B202020);

    // Reset asserted mid-scroll
    send(8'h0A); send(8'h0A); send(8'h0A);
    tick(); tick(); tick();
    check("mid_scroll_busy", 32'(busy), 1);
    resetn = 1'b0;
    #1;
    check_cursor("mid_rst_cursor", 0, 0);
    check("mid_rst_busy", 32'(busy), 1);
    check("mid_rst_rd_char", 32'(rd_char), 0);
    tick();
    resetn = 1'b1;
    wait_ready(cycles);
    check("mid_rst_clear_cycles", cycles, 12);
    check_blank();
    check_cursor("mid_rst_final", 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
